// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the CPU
// datapath (default owner) and an external burst master. A starvation counter
// bounds how long the external port can be held off by a busy CPU. While the
// external port owns the memory, CPU memory accesses are frozen via cpu_stall.
module dmem_arbiter #(
    parameter int WIDTH      = 8,
    parameter int LEN_WIDTH  = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // CPU side
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [WIDTH-1:0]     cpu_addr,
    input  logic [WIDTH-1:0]     cpu_wdata,
    output logic [WIDTH-1:0]     cpu_rdata,
    output logic                 cpu_stall,
    // External burst port
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [WIDTH-1:0]     ext_addr,
    input  logic [LEN_WIDTH-1:0] ext_len,
    input  logic [WIDTH-1:0]     ext_wdata,
    output logic                 ext_ack,
    output logic [LEN_WIDTH-1:0] ext_beat,
    output logic [WIDTH-1:0]     ext_rdata,
    output logic                 ext_done,
    // Data memory
    output logic [WIDTH-1:0]     mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    output logic                 mem_we,
    input  logic [WIDTH-1:0]     mem_rdata
);

    typedef enum logic {
        S_CPU = 1'b0,
        S_EXT = 1'b1
    } state_t;

    // Wait counter only needs to reach STARVE_LIM-1; keep at least one bit.
    localparam int WAIT_W = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIM - 1);

    state_t                 state_reg,    state_next;
    logic [WAIT_W-1:0]      wait_cnt_reg, wait_cnt_next;
    logic [LEN_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [WIDTH-1:0]       base_reg,     base_next;
    logic [LEN_WIDTH-1:0]   len_reg,      len_next;
    logic                   we_reg,       we_next;

    logic                   grant;
    logic                   last_beat;

    // Grant when the CPU leaves the memory free, or when the external port has
    // already waited the maximum number of cycles behind a busy CPU.
    assign grant     = (state_reg == S_CPU) && ext_req &&
                       (!cpu_req || (wait_cnt_reg == WAIT_MAX));
    assign last_beat = (state_reg == S_EXT) && (beat_cnt_reg == len_reg);

    // State and burst-context registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_CPU;
            wait_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            base_reg     <= '0;
            len_reg      <= '0;
            we_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            base_reg     <= base_next;
            len_reg      <= len_next;
            we_reg       <= we_next;
        end
    end

    // Next-state logic: arbitration in S_CPU, beat sequencing in S_EXT.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        base_next     = base_reg;
        len_next      = len_reg;
        we_next       = we_reg;

        case (state_reg)
            S_CPU: begin
                beat_cnt_next = '0;
                if (grant) begin
                    // Burst parameters are captured at the grant edge; the
                    // CPU access of this cycle still completes normally.
                    state_next    = S_EXT;
                    wait_cnt_next = '0;
                    base_next     = ext_addr;
                    len_next      = ext_len;
                    we_next       = ext_we;
                end else if (!ext_req) begin
                    wait_cnt_next = '0;
                end else if (cpu_req && (wait_cnt_reg != WAIT_MAX)) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_EXT: begin
                // External request inputs are ignored until the burst ends.
                if (last_beat) begin
                    state_next    = S_CPU;
                    beat_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = S_CPU;
                beat_cnt_next = '0;
            end
        endcase
    end

    // Output steering: memory port follows the owner of the current state.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req & cpu_we;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        ext_ack   = 1'b0;
        ext_beat  = '0;
        ext_rdata = '0;
        ext_done  = 1'b0;

        if (state_reg == S_EXT) begin
            // Address wraps naturally modulo 2^WIDTH.
            mem_addr  = base_reg + WIDTH'(beat_cnt_reg);
            mem_wdata = ext_wdata;
            mem_we    = we_reg;
            cpu_rdata = '0;
            // Only instructions that actually touch memory are frozen.
            cpu_stall = cpu_req;
            ext_ack   = 1'b1;
            ext_beat  = beat_cnt_reg;
            ext_rdata = mem_rdata;
            ext_done  = last_beat;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath and an external port (debug/loader/DMA).
- The CPU side is driven by the decoder's data-memory controls: address, write enable and access request.
- The external port performs bursts to incrementing addresses.
- The CPU has default priority. A starvation counter guarantees the external port a grant. While the external port owns the memory, the CPU is frozen via `cpu_stall`.

Parameters:
- `WIDTH`, 8, data and address width.
- `LEN_WIDTH`, 4, width of the burst-length field (burst = `ext_len`+1 beats, so 1..2^LEN_WIDTH).
- `STARVE_LIM`, 4, maximum number of consecutive cycles `ext_req` waits while the CPU holds the memory (must be >= 1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  CPU needs data memory this cycle (LD/ST/LDAR).
- `cpu_we`  in  1  CPU write (ST).
- `cpu_addr`  in  WIDTH  CPU address.
- `cpu_wdata`  in  WIDTH  CPU write data (accumulator).
- `cpu_rdata`  out  WIDTH  read data to the CPU operand-B mux.
- `cpu_stall`  out  1  freeze PC/ACC/register-file writes this cycle.
- `ext_req`  in  1  external burst request (level).
- `ext_we`  in  1  burst direction, 1 = write; sampled at grant.
- `ext_addr`  in  WIDTH  burst start address; sampled at grant.
- `ext_len`  in  LEN_WIDTH  beats-1; sampled at grant.
- `ext_wdata`  in  WIDTH  write data for the current beat.
- `ext_ack`  out  1  a beat is performed this cycle.
- `ext_beat`  out  LEN_WIDTH  index of the current beat.
- `ext_rdata`  out  WIDTH  read data, valid while `ext_ack`=1.
- `ext_done`  out  1  last beat of the burst (coincides with `ext_ack`).
- `mem_addr`  out  WIDTH  to data memory.
- `mem_wdata`  out  WIDTH  to data memory.
- `mem_we`  out  1  to data memory (write at rising edge).
- `mem_rdata`  in  WIDTH  from data memory (combinational read).

Behaviour:
- **States:**
  - S_CPU: the CPU owns memory; this is the reset state.
  - S_EXT: the external burst is in progress.
- **Reset (async, `rst_n`=0):**
  - State = S_CPU; `wait_cnt`, `beat_cnt`, latched address/length/we are all cleared to 0.
  - Outputs then follow the S_CPU rules: `cpu_stall`=0, `ext_ack`=0, `ext_done`=0, `ext_beat`=0, `ext_rdata`=0.
  - `mem_we`=`cpu_req`&`cpu_we`.
  - Reset mid-burst abandons the burst; no further ext writes occur.
- **S_CPU outputs (combinational):**
  - `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_we`=`cpu_req`&`cpu_we`, `cpu_rdata`=`mem_rdata`.
  - `cpu_stall`=0, `ext_ack`=0.
- **`wait_cnt`, updated in S_CPU:**
  - Increments when `ext_req`&`cpu_req`.
  - Clears when `ext_req`=0 or on the transition to S_EXT.
  - Saturates at `STARVE_LIM`-1.
- **S_CPU -> S_EXT:**
  - Taken when `ext_req` & (!`cpu_req` | `wait_cnt`==`STARVE_LIM`-1).
  - At that edge, latch `base`=`ext_addr`, `len`=`ext_len`, `we`=`ext_we`, and set `beat_cnt`=0.
  - The current-cycle CPU access still completes in S_CPU.
  - Grant-to-first-beat latency is 1 cycle.
- **S_EXT outputs:**
  - `mem_addr`=`base`+`beat_cnt`, modulo 2^WIDTH (wraps 0xFF -> 0x00).
  - `mem_wdata`=`ext_wdata`, `mem_we`=`we`, `ext_rdata`=`mem_rdata`.
  - `ext_ack`=1, `ext_beat`=`beat_cnt`, `ext_done`=(`beat_cnt`==`len`).
  - `cpu_stall`=`cpu_req`; `cpu_rdata`=0.
  - CPU instructions without a memory access are never stalled.
- **S_EXT sequencing:**
  - One beat per cycle; `beat_cnt` increments each cycle.
  - When `ext_done`=1, the next state is S_CPU and `beat_cnt` clears.
  - A burst of `len`+1 beats occupies exactly `len`+1 cycles.
  - `ext_req`, `ext_addr`, `ext_len` and `ext_we` are ignored during S_EXT.
- **Back-to-back requests:** if `ext_req` is still high after `ext_done`, it is a new request arbitrated normally from S_CPU. There is at least one S_CPU cycle between bursts, so the CPU always gets a slot.
- **`STARVE_LIM`=1:** `ext_req` is granted on its first cycle regardless of `cpu_req`.
- **Data hazards:** none handled; ext writes and CPU accesses to the same address are ordered by the grant sequence.

Test Plan:
- **Idle CPU read:**
  - Stimulus: `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x10, mem[0x10]=0x5A, `ext_req`=0.
  - Required: `cpu_rdata`=0x5A, `cpu_stall`=0, `mem_we`=0.
- **Ext write burst, CPU idle:**
  - Stimulus: `ext_req`=1, `ext_we`=1, `ext_addr`=0x20, `ext_len`=3, `ext_wdata`=0xA0+`ext_beat`.
  - Required: 1 cycle after request, 4 consecutive `ext_ack` beats.
  - Required: mem[0x20..0x23]=A0..A3; `ext_done` on beat 3; return to S_CPU.
- **Starvation:**
  - Stimulus: `cpu_req` held 1, `ext_req` raised at cycle 0, `STARVE_LIM`=4.
  - Required: grant edge at end of cycle 3; `cpu_stall`=1 from cycle 4 for `len`+1 cycles; CPU resumes afterwards.
- **Address wrap:**
  - Stimulus: `ext_addr`=0xFE, `ext_len`=2, read burst.
  - Required: `mem_addr` sequence 0xFE, 0xFF, 0x00; `ext_rdata` matches memory.
- **Reset mid-burst:**
  - Stimulus: `rst_n`=0 during beat 1 of a 4-beat write burst.
  - Required: immediately `ext_ack`=0 and `mem_we` follows the CPU; beats 2 and 3 are never written; state S_CPU.
- **Non-memory CPU op during burst:**
  - Stimulus: `cpu_req`=0 while in S_EXT.
  - Required: `cpu_stall`=0; the burst is unaffected.
